stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised, registered N:1 stream multiplexer with valid/ready handshakes. It is the sequential successor of the combinational 8:1 bit mux.
- It arbitrates among N_CH input channels, each WIDTH bits wide. Arbitration is either round-robin or fixed-priority.
- The winning word and its channel index are captured into a single output register.
- Used wherever several producers share one downstream consumer.

Parameters:
- N_CH, 8, number of input channels (>= 2; need not be a power of 2).
- WIDTH, 8, data bits per channel.
- SEL_W, 3, channel index width; must equal ceil(log2(N_CH)).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready (one-hot or zero).
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out_data  output  WIDTH  registered winning word.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - Asserting rst mid-transfer discards any held word. No in_ready is asserted while rst is high.
- Load enable: ld = ~out_valid | out_ready. The output register may accept a new word when it is empty, or when it is being drained in the same cycle.
- Grant, combinational, evaluated only when ld=1:
  - mode=1: lowest index i with in_valid[i]=1.
  - mode=0: first i with in_valid[i]=1, searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
  - No valid input, or ld=0: no grant.
- in_ready[i] = ld & grant[i]. At most one bit is set. in_ready must not depend on in_data.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= word g, out_ch <= g, out_valid <= 1.
  - If mode=0: ptr <= g+1, or 0 when g = N_CH-1 (wrap).
  - If mode=1: ptr is unchanged.
- Drain without refill (out_valid & out_ready, no transfer): out_valid <= 0. out_data and out_ch hold their values.
- Stall (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold; all in_ready=0.
- Simultaneous drain and refill in the same cycle: the new word replaces the old one, out_valid stays 1, no bubble.
- Throughput and latency:
  - Sustained throughput is 1 word/clk while out_ready=1.
  - Input handshake to out_valid is 1 cycle.
- Mode change:
  - Applies to the very next arbitration.
  - ptr is retained across mode changes, so returning to mode=0 resumes from the stored pointer.
- Fairness: in mode=0, with all channels continuously valid, each channel is granted exactly once per N_CH consecutive transfers.
- Producer rule: producers must hold in_valid and in_data until their handshake completes. Starvation in mode=1 is permitted by design.

Test Plan:
- Reset: assert rst with in_valid=8'hFF and out_ready=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release, first grant goes to ch0.
- Round-robin sweep: mode=0, in_valid=8'hFF, in_data byte i = 8'h10+i, out_ready=1 -> out_ch sequence 0,1,...,7,0 on consecutive cycles. out_data = 8'h10..8'h17, then 8'h10.
- Fixed priority: mode=1, in_valid=8'b1010_0100 held for 3 transfers -> out_ch=2 each time; ch5 and ch7 never granted.
- Backpressure: out_ready=0 after first word (ch3, data 8'hA5) -> out_valid=1, out_data=8'hA5 and out_ch=3 held for 4 cycles, in_ready=0. Raise out_ready -> next word appears one cycle later with no loss.
- Wrap and sparse: mode=0, ptr=6 (after a ch5 grant), in_valid=8'b0000_0011 -> grant ch0, then ch1.
- N_CH=5, WIDTH=16, SEL_W=3 build: all valid -> out_ch 0,1,2,3,4,0. Async reset mid-stall clears out_valid immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N:1 valid/ready stream multiplexer.
// Arbitration is round-robin (mode=0, resumes after the last winner) or
// fixed-priority (mode=1, lowest index wins). The winning word and its
// channel index land in a single output register that refills in the same
// cycle it drains, so a continuously ready sink sees one word per clock.
module stream_mux_rr #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // One spare bit so ptr + offset cannot overflow before the wrap subtract.
  localparam int unsigned CNT_W = SEL_W + 1;
  localparam logic [CNT_W-1:0] N_CH_C  = CNT_W'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [WIDTH-1:0] words [N_CH];

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             ld_c;
  logic             found_c;
  logic [SEL_W-1:0] gidx_c;
  logic [CNT_W-1:0] cand_c;
  logic [N_CH-1:0]  grant_c;

  // Unpack the flat input bus into per-channel words.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign words[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Arbiter: scan channels from the start point (ptr or 0) and pick the
  // first valid one; nothing is granted while the output register is full
  // and stalled, or while reset is asserted.
  always_comb begin
    ld_c    = (~out_valid_q | out_ready) & ~rst;
    found_c = 1'b0;
    gidx_c  = '0;
    cand_c  = '0;
    grant_c = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (mode) begin
        cand_c = CNT_W'(k);
      end else begin
        cand_c = {1'b0, ptr_q} + CNT_W'(k);
      end
      if (cand_c >= N_CH_C) begin
        cand_c = cand_c - N_CH_C;
      end
      if (ld_c && !found_c && in_valid[cand_c[SEL_W-1:0]]) begin
        found_c = 1'b1;
        gidx_c  = cand_c[SEL_W-1:0];
      end
    end
    if (found_c) begin
      grant_c[gidx_c] = 1'b1;
    end
  end

  // Next-state: load the winner, otherwise drain or hold the output word.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (found_c) begin
      out_data_d  = words[gidx_c];
      out_ch_d    = gidx_c;
      out_valid_d = 1'b1;
      if (!mode) begin
        ptr_d = (gidx_c == LAST_CH) ? '0 : gidx_c + SEL_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = grant_c;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: an 8-channel instance and a 5-channel/16-bit
// instance. Stimulus pushes expected {ch,data} words into per-instance
// queues; negedge monitors pop and compare whenever a word is accepted.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic        rst8;
  logic [63:0] in_data8;
  logic [7:0]  in_valid8, in_ready8;
  logic        mode8;
  logic [7:0]  out_data8;
  logic [2:0]  out_ch8;
  logic        out_valid8, out_ready8;

  // 5-channel, 16-bit instance
  logic        rst5;
  logic [79:0] in_data5;
  logic [4:0]  in_valid5, in_ready5;
  logic        mode5;
  logic [15:0] out_data5;
  logic [2:0]  out_ch5;
  logic        out_valid5, out_ready5;

  int checks   = 0;
  int failures = 0;

  logic [10:0] sb8[$];
  logic [18:0] sb5[$];

  stream_mux_rr #(.N_CH(8), .WIDTH(8), .SEL_W(3)) dut8 (
    .clk(clk), .rst(rst8), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .mode(mode8), .out_data(out_data8),
    .out_ch(out_ch8), .out_valid(out_valid8), .out_ready(out_ready8)
  );

  stream_mux_rr #(.N_CH(5), .WIDTH(16), .SEL_W(3)) dut5 (
    .clk(clk), .rst(rst5), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .mode(mode5), .out_data(out_data5),
    .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] base8();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(i + 16);
    return d;
  endfunction

  function automatic logic [79:0] base5();
    logic [79:0] d;
    for (int i = 0; i < 5; i++) d[i*16 +: 16] = 16'(i + 32'hA000);
    return d;
  endfunction

  // Scoreboard monitor, 8-channel instance
  always @(negedge clk) begin
    logic [10:0] e;
    if (out_valid8 && out_ready8) begin
      if (sb8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb8_unexpected actual ch=%0d data=%0h expected none", out_ch8, out_data8);
      end else begin
        e = sb8.pop_front();
        chk("sb8_word", 32'({out_ch8, out_data8}), 32'(e));
      end
    end
  end

  // Scoreboard monitor, 5-channel instance
  always @(negedge clk) begin
    logic [18:0] e;
    if (out_valid5 && out_ready5) begin
      if (sb5.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb5_unexpected actual ch=%0d data=%0h expected none", out_ch5, out_data5);
      end else begin
        e = sb5.pop_front();
        chk("sb5_word", 32'({out_ch5, out_data5}), 32'(e));
      end
    end
  end

  initial begin
    logic [10:0] rr_exp [9];
    logic [18:0] rr5_exp [5];
    rr_exp  = '{{3'd0, 8'h10}, {3'd1, 8'h11}, {3'd2, 8'h12}, {3'd3, 8'h13},
                {3'd4, 8'h14}, {3'd5, 8'h15}, {3'd6, 8'h16}, {3'd7, 8'h17},
                {3'd0, 8'h10}};
    rr5_exp = '{{3'd0, 16'hA000}, {3'd1, 16'hA001}, {3'd2, 16'hA002},
                {3'd3, 16'hA003}, {3'd4, 16'hA004}};

    rst8 = 1'b1; in_valid8 = 8'hFF; out_ready8 = 1'b1; mode8 = 1'b0; in_data8 = base8();
    rst5 = 1'b1; in_valid5 = 5'h1F; out_ready5 = 1'b1; mode5 = 1'b0; in_data5 = base5();

    // Reset with all inputs valid and sink ready
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid8", 32'(out_valid8), 32'd0);
    chk("rst_data8",  32'(out_data8),  32'd0);
    chk("rst_ch8",    32'(out_ch8),    32'd0);
    chk("rst_ready8", 32'(in_ready8),  32'd0);
    chk("rst_ready5", 32'(in_ready5),  32'd0);

    // Round-robin sweep: 0..7 then 0, one word per clock
    @(posedge clk); #1;
    rst8 = 1'b0;
    for (int i = 0; i < 9; i++) sb8.push_back(rr_exp[i]);
    @(negedge clk);
    chk("first_grant8", 32'(in_ready8), 32'h01);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk("rr_valid8", 32'(out_valid8), 32'd1);
    end
    in_valid8 = 8'h00;
    @(posedge clk); #1;

    // Fixed priority: ch2 beats ch5 and ch7 every time
    mode8 = 1'b1;
    in_valid8 = 8'b1010_0100;
    repeat (3) sb8.push_back({3'd2, 8'h12});
    @(negedge clk);
    chk("fp_ready8", 32'(in_ready8), 32'h04);
    repeat (3) @(posedge clk);
    #1;
    in_valid8 = 8'h00;
    mode8 = 1'b0;
    @(posedge clk); #1;

    // Backpressure: ch3 word held through a 4-cycle stall, then ch4 follows
    in_data8 = base8();
    in_data8[3*8 +: 8] = 8'hA5;
    in_data8[4*8 +: 8] = 8'h5A;
    in_valid8 = 8'h08;
    sb8.push_back({3'd3, 8'hA5});
    sb8.push_back({3'd4, 8'h5A});
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    in_valid8 = 8'h10;
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid8", 32'(out_valid8), 32'd1);
      chk("bp_data8",  32'(out_data8),  32'hA5);
      chk("bp_ch8",    32'(out_ch8),    32'd3);
      chk("bp_ready8", 32'(in_ready8),  32'd0);
    end
    @(posedge clk); #1;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_next_ch8",   32'(out_ch8),   32'd4);
    chk("bp_next_data8", 32'(out_data8), 32'h5A);
    in_valid8 = 8'h00;
    @(posedge clk); #1;

    // Wrap and sparse: ch5 grant leaves ptr=6, then ch0 and ch1 win
    in_data8 = base8();
    in_valid8 = 8'h20;
    sb8.push_back({3'd5, 8'h15});
    sb8.push_back({3'd0, 8'h10});
    sb8.push_back({3'd1, 8'h11});
    @(posedge clk); #1;
    in_valid8 = 8'h03;
    @(negedge clk);
    chk("wrap_ready0", 32'(in_ready8), 32'h01);
    @(posedge clk); #1;
    chk("wrap_ready1", 32'(in_ready8), 32'h02);
    @(posedge clk); #1;
    in_valid8 = 8'h00;

    // 5-channel build: 0..4 then 0, stall, async reset between edges
    rst5 = 1'b0;
    for (int i = 0; i < 5; i++) sb5.push_back(rr5_exp[i]);
    repeat (6) @(posedge clk);
    #1;
    out_ready5 = 1'b0;
    @(negedge clk);
    chk("stall_valid5", 32'(out_valid5), 32'd1);
    chk("stall_ch5",    32'(out_ch5),    32'd0);
    chk("stall_data5",  32'(out_data5),  32'hA000);
    chk("stall_ready5", 32'(in_ready5),  32'd0);
    #2;
    rst5 = 1'b1;
    #1;
    chk("arst_valid5", 32'(out_valid5), 32'd0);
    chk("arst_data5",  32'(out_data5),  32'd0);
    chk("arst_ch5",    32'(out_ch5),    32'd0);
    chk("arst_ready5", 32'(in_ready5),  32'd0);
    in_valid5 = 5'h00;

    // Every expected word must have been consumed
    for (int n = 0; n < 10 && (sb8.size() + sb5.size()) != 0; n++) @(negedge clk);
    chk("sb_drained", 32'(sb8.size() + sb5.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
